// File: rtl/not_unit_arbiter.sv
// Shared bitwise inverter arbitrated round-robin among four requesters,
// with a single-entry result register that drains and refills with no bubble.
module not_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] op_a,
    output logic [3:0]         ack,
    output logic               res_valid,
    output logic [WIDTH-1:0]   res_data,
    output logic [1:0]         res_id,
    input  logic               res_ready,
    output logic               busy,
    output logic [15:0]        op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_p1;
    logic [1:0]       ptr_p1;
    logic [1:0]       grant_p0;
    logic             slot_free_p0;
    logic             accept_p0;
    logic [WIDTH-1:0] sel_op_p0;

    assign res_valid = (state_p1 == FULL);

    // Round-robin search starts just above the last grant.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant_p0 = ptr_p1;
        found    = 1'b0;
        idx      = ptr_p1;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_p1 + 2'(k);
            if (!found && req[idx]) begin
                grant_p0 = idx;
                found    = 1'b1;
            end
        end
    end

    assign slot_free_p0 = !res_valid || res_ready;
    assign accept_p0    = rst_n && slot_free_p0 && (|req);
    assign ack          = accept_p0 ? (4'b0001 << grant_p0) : 4'b0000;
    assign busy         = res_valid || (|req);
    assign sel_op_p0    = op_a[int'(grant_p0)*WIDTH +: WIDTH];

    // ---- stage p0 -> p1: result register, arbitration pointer, handshake count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= EMPTY;
            ptr_p1   <= 2'd3;
            res_data <= '0;
            res_id   <= 2'd0;
            op_count <= 16'd0;
        end else begin
            if (res_valid && res_ready) begin
                op_count <= op_count + 16'd1;
            end
            case (state_p1)
                EMPTY: begin
                    if (accept_p0) begin
                        res_data <= ~sel_op_p0;
                        res_id   <= grant_p0;
                        ptr_p1   <= grant_p0;
                        state_p1 <= FULL;
                    end
                end
                FULL: begin
                    if (accept_p0) begin
                        res_data <= ~sel_op_p0;
                        res_id   <= grant_p0;
                        ptr_p1   <= grant_p0;
                        state_p1 <= FULL;
                    end else if (res_ready) begin
                        state_p1 <= EMPTY;
                    end
                end
                default: state_p1 <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_not_unit_arbiter.sv
// Randomized and directed bench for not_unit_arbiter against a behavioural
// model of the arbitration and result-slot rules.
module tb_not_unit_arbiter;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] op_a;
    logic [3:0]         ack;
    logic               res_valid;
    logic [WIDTH-1:0]   res_data;
    logic [1:0]         res_id;
    logic               res_ready;
    logic               busy;
    logic [15:0]        op_count;

    int tests = 0;
    int fails = 0;

    not_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .ack(ack),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: what the outputs must be after the most recent edge.
    bit       m_valid = 0;
    int       m_data  = 0;
    int       m_id    = 0;
    int       m_ptr   = 3;
    int       m_count = 0;
    int       wait_cnt [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        int g;
        bit acc;
        int exp_ack;
        if (!rst_n) begin
            chk("rst_valid", res_valid, 0);
            chk("rst_ack", ack, 0);
            chk("rst_count", op_count, 0);
            m_valid = 0; m_data = 0; m_id = 0; m_ptr = 3; m_count = 0;
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        end else begin
            g = -1;
            for (int k = 1; k <= 4; k++)
                if (g < 0 && req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            acc = (!m_valid || res_ready) && (g >= 0);
            exp_ack = acc ? (1 << g) : 0;
            chk("ack", ack, exp_ack);
            chk("busy", busy, m_valid || (req != 0));
            chk("res_valid", res_valid, m_valid);
            chk("op_count", op_count, m_count);
            if (m_valid) begin
                chk("res_data", res_data, m_data);
                chk("res_id", res_id, m_id);
            end
            if (acc) begin
                for (int i = 0; i < 4; i++) begin
                    if (req[i] && i != g) begin
                        wait_cnt[i]++;
                        chk("fairness", wait_cnt[i] < 4, 1);
                    end else begin
                        wait_cnt[i] = 0;
                    end
                end
            end
            if (m_valid && res_ready) m_count = (m_count + 1) % 65536;
            if (acc) begin
                m_data  = (~op_a[g*WIDTH +: WIDTH]) & 8'hFF;
                m_id    = g;
                m_ptr   = g;
                m_valid = 1;
            end else if (res_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        req = 4'h0; res_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rr_exp [4];
        rr_exp[0] = 8'hFF; rr_exp[1] = 8'hF0; rr_exp[2] = 8'h0F; rr_exp[3] = 8'h00;
        rst_n = 1'b0; req = 4'h0; op_a = '0; res_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // Single operation
        req = 4'b0001; op_a = 32'h0000_005A; res_ready = 1'b1;
        @(negedge clk); chk("single_ack", ack, 4'b0001);
        step(); req = 4'b0000;
        @(negedge clk);
        chk("single_valid", res_valid, 1);
        chk("single_data", res_data, 8'hA5);
        chk("single_id", res_id, 0);
        step();
        @(negedge clk); chk("single_count", op_count, 1);

        // Round robin with all requesters
        do_reset();
        req = 4'hF; op_a = 32'hFFF0_0F00; res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_ack", ack, 4'b0001 << (i % 4));
            if (i >= 1) begin
                chk("rr_data", res_data, rr_exp[(i - 1) % 4]);
                chk("rr_id", res_id, (i - 1) % 4);
            end
            step();
        end

        // Backpressure, then priority after grant 2
        do_reset();
        req = 4'b0001; op_a = 32'h0000_005A; res_ready = 1'b1;
        step();
        req = 4'b0100; op_a = 32'h0033_0000; res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ack", ack, 0);
            chk("bp_data", res_data, 8'hA5);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk); chk("bp_release_ack", ack, 4'b0100);
        step();
        req = 4'b1011; op_a = 32'h1122_3344;
        @(negedge clk);
        chk("bp_new_data", res_data, 8'hCC);
        chk("bp_new_id", res_id, 2);
        chk("prio_ack0", ack, 4'b1000);
        step(); @(negedge clk); chk("prio_ack1", ack, 4'b0001);
        step(); @(negedge clk); chk("prio_ack2", ack, 4'b0010);

        // Asynchronous reset mid-cycle while FULL and requests pending
        step();
        req = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_ack", ack, 0);
        chk("arst_count", op_count, 0);
        chk("arst_data", res_data, 0);
        step();
        rst_n = 1'b1;

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            req       = 4'($urandom_range(0, 15));
            op_a      = 32'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        // Handshake counter wrap
        do_reset();
        req = 4'hF; op_a = 32'($urandom); res_ready = 1'b1;
        repeat (65536) step();
        req = 4'h0;
        step(); step();
        @(negedge clk); chk("wrap_zero", op_count, 16'h0000);
        step();
        req = 4'b0010;
        step();
        req = 4'h0;
        step(); step();
        @(negedge clk); chk("wrap_one", op_count, 16'h0001);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
